// File: rtl/adc_pkg.sv
// ============================================================================
// Package : adc_pkg
// Shared constants, FSM state type and the 17-bit magnitude helper for the
// 8-channel ADC window averager.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // |v| of a signed 16-bit word, one bit wider so that -32768 maps to 32768
  function automatic logic [SAMPLE_W:0] mag17(input logic [SAMPLE_W-1:0] v);
    logic [SAMPLE_W:0] ext;
    ext = {v[SAMPLE_W-1], v};
    return ext[SAMPLE_W] ? (~ext + 1'b1) : ext;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_chan_avg.sv
// ============================================================================
// Module  : adc_chan_avg
// Eight-channel boxcar averager. Each accepted ADC frame is snapshotted and
// folded into per-channel accumulators one channel per cycle through a single
// shared adder. After 2^AVG_LOG2 frames the floored averages are published
// with a one-cycle avg_valid pulse.
// Optional build macro: ADC_AVG_ALARM_EN -- enables the per-channel
// |avg| > ALARM_TH alarm comparators; otherwise alarm is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_chan_avg
  import adc_pkg::*;
#(
  parameter int          AVG_LOG2 = 3,
  parameter logic [15:0] ALARM_TH = 16'd30000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
  input  logic                         clr,
  input  logic                         ovr_clr,
  output logic [NUM_CH*SAMPLE_W-1:0]   avg_data,
  output logic                         avg_valid,
  output logic [NUM_CH-1:0]            alarm,
  output logic                         busy,
  output logic                         overrun
);

  // Accumulator holds 2^AVG_LOG2 sign-extended samples without overflow
  localparam int                ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int                CNT_W = AVG_LOG2 + 1;
  localparam int                IDX_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0]  WIN   = CNT_W'(2 ** AVG_LOG2);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_CH - 1);

  state_t                      state;
  logic signed [SAMPLE_W-1:0]  snap [NUM_CH];
  logic signed [ACC_W-1:0]     acc  [NUM_CH];
  logic [IDX_W-1:0]            ch_idx;
  logic [CNT_W-1:0]            sample_cnt;

  logic signed [SAMPLE_W-1:0]  sel_snap;
  logic signed [ACC_W-1:0]     sel_acc;
  logic signed [ACC_W-1:0]     acc_sum;
  logic [SAMPLE_W-1:0]         avg_next [NUM_CH];

  // Single shared adder: the channel selected by ch_idx is folded in each cycle
  always_comb begin
    sel_snap = snap[ch_idx];
    sel_acc  = acc[ch_idx];
    acc_sum  = sel_acc + ACC_W'(sel_snap);
  end

  // Arithmetic shift right by AVG_LOG2 then truncation to 16 bits is exactly
  // this bit window of the accumulator; rounding is toward minus infinity
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      avg_next[i] = acc[i][AVG_LOG2 +: SAMPLE_W];
    end
  end

  assign busy = (state != ST_IDLE);

  // Control FSM, datapath registers, averaged outputs and overrun flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ch_idx     <= '0;
      sample_cnt <= '0;
      avg_data   <= '0;
      avg_valid  <= 1'b0;
      overrun    <= 1'b0;
`ifdef ADC_AVG_ALARM_EN
      alarm      <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        snap[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      avg_valid <= 1'b0;

      // A frame arriving while the datapath is busy is lost; set beats clear
      if (sample_valid && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      if (clr) begin
        // Window restart: outputs keep their last published values
        state      <= ST_IDLE;
        ch_idx     <= '0;
        sample_cnt <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          acc[i] <= '0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (sample_valid) begin
              for (int i = 0; i < NUM_CH; i++) begin
                snap[i] <= ch_data[i*SAMPLE_W +: SAMPLE_W];
              end
              ch_idx <= '0;
              state  <= ST_ACCUM;
            end
          end

          ST_ACCUM: begin
            acc[ch_idx] <= acc_sum;
            ch_idx      <= ch_idx + 1'b1;
            if (ch_idx == LAST) begin
              sample_cnt <= sample_cnt + 1'b1;
              state      <= ((sample_cnt + 1'b1) == WIN) ? ST_DONE : ST_IDLE;
            end
          end

          ST_DONE: begin
            for (int i = 0; i < NUM_CH; i++) begin
              avg_data[i*SAMPLE_W +: SAMPLE_W] <= avg_next[i];
`ifdef ADC_AVG_ALARM_EN
              alarm[i] <= (mag17(avg_next[i]) > {1'b0, ALARM_TH});
`endif
              acc[i] <= '0;
            end
            avg_valid  <= 1'b1;
            sample_cnt <= '0;
            state      <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifndef ADC_AVG_ALARM_EN
  // Alarm feature not built: port kept for a stable interface
  assign alarm = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_chan_avg.sv
// ============================================================================
// Testbench : tb_adc_chan_avg
// Scoreboard bench for adc_chan_avg. Two instances share the stimulus: the
// default window (AVG_LOG2=3) and a pass-through window (AVG_LOG2=0).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_chan_avg;

  typedef struct packed {
    logic [127:0] d;
    logic [7:0]   a;
  } exp_t;

`ifdef ADC_AVG_ALARM_EN
  localparam logic [7:0] A_W1 = 8'b0110_0000;
  localparam logic [7:0] A_W4 = 8'b1010_0000;
`else
  localparam logic [7:0] A_W1 = 8'b0000_0000;
  localparam logic [7:0] A_W4 = 8'b0000_0000;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_valid = 1'b0;
  logic [127:0] ch_data = '0;
  logic         clr = 1'b0;
  logic         ovr_clr = 1'b0;

  logic [127:0] avg_data,  avg_data0;
  logic         avg_valid, avg_valid0;
  logic [7:0]   alarm,     alarm0;
  logic         busy,      busy0;
  logic         overrun,   overrun0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  exp_t q[$];
  exp_t q0[$];
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  adc_chan_avg #(.AVG_LOG2(3), .ALARM_TH(16'd30000)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .ch_data(ch_data),
    .clr(clr), .ovr_clr(ovr_clr), .avg_data(avg_data), .avg_valid(avg_valid),
    .alarm(alarm), .busy(busy), .overrun(overrun));

  adc_chan_avg #(.AVG_LOG2(0), .ALARM_TH(16'd30000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .ch_data(ch_data),
    .clr(clr), .ovr_clr(ovr_clr), .avg_data(avg_data0), .avg_valid(avg_valid0),
    .alarm(alarm0), .busy(busy0), .overrun(overrun0));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [15:0] c7, c6, c5, c4, c3, c2, c1, c0);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic logic [127:0] rep(input logic [15:0] x);
    return {8{x}};
  endfunction

  // Alarm expected from a pass-through window (value equals the sample)
  function automatic logic [7:0] alarm_model(input logic [127:0] v);
    logic [7:0] a;
    a = '0;
`ifdef ADC_AVG_ALARM_EN
    for (int i = 0; i < 8; i++) begin
      int s;
      s = $signed(v[16*i +: 16]);
      if (s < 0) s = -s;
      a[i] = (s > 30000);
    end
`endif
    return a;
  endfunction

  // One accepted frame, spaced so both instances are back in IDLE afterwards
  task automatic send(input logic [127:0] v);
    @(negedge clk);
    ch_data = v;
    sample_valid = 1'b1;
    q0.push_back('{d: v, a: alarm_model(v)});
    @(posedge clk);
    #1 sample_valid = 1'b0;
    repeat (9) @(posedge clk);
  endtask

  // Same as send, but checks that avg_valid is high only between edges 9 and 10
  task automatic send_timed(input logic [127:0] v);
    @(negedge clk);
    ch_data = v;
    sample_valid = 1'b1;
    q0.push_back('{d: v, a: alarm_model(v)});
    @(posedge clk);
    #1 sample_valid = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1 chk($sformatf("latency_edge%0d", e), avg_valid, (e == 9));
    end
  endtask

  // Scoreboard monitor for the averaging instance
  always @(negedge clk) begin
    if (rst_n && avg_valid) begin
      exp_t e;
      n_pulse++;
      chk("no_back_to_back", prev_v, 1'b0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL avg_unexpected: got avg_valid with data %h, expected no pulse", avg_data);
      end else begin
        e = q.pop_front();
        chk("avg_data", avg_data, e.d);
        chk("alarm", alarm, e.a);
      end
    end
    prev_v = avg_valid;
  end

  // Scoreboard monitor for the pass-through instance
  always @(negedge clk) begin
    if (rst_n && avg_valid0) begin
      exp_t e;
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pass_unexpected: got avg_valid with data %h, expected no pulse", avg_data0);
      end else begin
        e = q0.pop_front();
        chk("pass_data", avg_data0, e.d);
        chk("pass_alarm", alarm0, e.a);
      end
    end
  end

  initial begin
    logic [127:0] v;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_avg_valid", avg_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_avg_data", avg_data, '0);
    chk("rst_alarm", alarm, '0);

    // Window 1: ramps, constants, floored negative averages, extremes
    for (int k = 0; k < 8; k++) begin
      v = mk(16'(k * 1000), 16'h8000, 16'h7FFF, 16'(-k),
             (k == 7) ? 16'hFFFF : 16'h0000, 16'hFFFD, 16'hFFFF, 16'(k));
      if (k < 7) begin
        send(v);
      end else begin
        q.push_back('{d: mk(16'h0DAC, 16'h8000, 16'h7FFF, 16'hFFFC,
                            16'hFFFF, 16'hFFFD, 16'hFFFF, 16'h0003), a: A_W1});
        send_timed(v);
      end
    end

    // Window 2: dropped frames, overrun set/clear, set beats clear
    @(negedge clk);
    ch_data = rep(16'd5);
    sample_valid = 1'b1;
    q0.push_back('{d: rep(16'd5), a: 8'h00});
    @(posedge clk);                       // edge 0
    #1 sample_valid = 1'b0;
    chk("busy_in_accum", busy, 1'b1);
    repeat (3) @(posedge clk);            // edges 1..3
    #1 ch_data = rep(16'd999);
    sample_valid = 1'b1;
    @(posedge clk);                       // edge 4: dropped
    #1 sample_valid = 1'b0;
    chk("overrun_set", overrun, 1'b1);
    sample_valid = 1'b1;
    ovr_clr = 1'b1;
    @(posedge clk);                       // edge 5: drop with clear
    #1 sample_valid = 1'b0;
    ovr_clr = 1'b0;
    chk("overrun_set_wins", overrun, 1'b1);
    repeat (5) @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    chk("overrun_cleared", overrun, 1'b0);
    for (int k = 0; k < 7; k++) begin
      if (k == 6) q.push_back('{d: rep(16'd5), a: 8'h00});
      send(rep(16'd5));
    end

    // Window 3: partial window discarded by clr (clr beats sample_valid)
    for (int k = 0; k < 5; k++) send(rep(16'd1000));
    @(negedge clk);
    ch_data = rep(16'd1000);
    sample_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    clr = 1'b0;
    chk("clr_keeps_avg", avg_data, rep(16'd5));
    chk("clr_idle", busy, 1'b0);
    chk("clr_no_overrun", overrun, 1'b0);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) q.push_back('{d: rep(16'd20), a: 8'h00});
      send(rep(16'd20));
    end

    // Window 4: alarm thresholds
    v = mk(16'h8ACF, 16'h7530, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) q.push_back('{d: v, a: A_W4});
      send(v);
    end

    // Window 5: reset during ACCUM of the 8th frame abandons everything
    for (int k = 0; k < 7; k++) send(rep(16'd100));
    @(negedge clk);
    ch_data = rep(16'd100);
    sample_valid = 1'b1;
    @(posedge clk);                       // edge 0
    #1 sample_valid = 1'b0;
    @(posedge clk);                       // edge 1
    #1 sample_valid = 1'b1;
    @(posedge clk);                       // edge 2: dropped
    #1 sample_valid = 1'b0;
    chk("overrun_before_rst", overrun, 1'b1);
    @(posedge clk);                       // edge 3
    #1 rst_n = 1'b0;
    @(posedge clk);                       // edge 4: reset
    #1 rst_n = 1'b1;
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_overrun", overrun, 1'b0);
    chk("rst2_avg_data", avg_data, '0);
    chk("rst2_alarm", alarm, '0);
    repeat (12) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) q.push_back('{d: rep(16'd7), a: 8'h00});
      send(rep(16'd7));
    end

    // Drain and totals
    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", 128'(q.size()), '0);
    chk("pass_queue_drained", 128'(q0.size()), '0);
    chk("pulse_count", 128'(n_pulse), 128'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
